sram_responder: RTL

- Synthesizable responder for the SLC-3 external SRAM bus: the memory end that the slc3 datapath drives through CE/UB/LB/OE/WE/ADDR/Data.
- Replaces the behavioural test memory so the toplevel and the week-2 benches run against a cycle-accurate, latency-configurable memory.
- Adds a side-band load port so program images (I/O, XOR, multiply, sort tests) are preloaded before Run is released.

---
 rtl/sram_pkg.sv | 14 +
 rtl/sram_if.sv | 15 +
 rtl/sram_array.sv | 35 +++
 rtl/sram_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SLC-3 external SRAM responder.
// Defines FSM states, decoded bus requests, byte-lane indices and the float word.
package sram_pkg;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE} state_t;

    typedef enum logic [1:0] {REQ_NONE, REQ_RD, REQ_WR} req_t;

    localparam int unsigned HI_LANE = 1;
    localparam int unsigned LO_LANE = 0;

    localparam logic [15:0] Z_WORD = 16'hzzzz;

endpackage

// File: rtl/sram_if.sv
// Control half of the SLC-3 SRAM bus; the datapath is master, the memory is slave.
// The bidirectional Data bus is carried as a plain inout port alongside it.
interface sram_if;

    logic        CE;
    logic        UB;
    logic        LB;
    logic        OE;
    logic        WE;
    logic [19:0] ADDR;

    modport master (output CE, UB, LB, OE, WE, ADDR);
    modport slave  (input  CE, UB, LB, OE, WE, ADDR);

endinterface

// File: rtl/sram_array.sv
// Word storage with per-byte bus writes, a full-word load port that wins
// over the bus, and an asynchronous read port. Contents survive reset.
module sram_array #(
    parameter int unsigned DEPTH_W = 10,
    parameter int unsigned DATA_W  = 16
) (
    input  logic               clk,
    input  logic               bus_we,
    input  logic [1:0]         bus_be,
    input  logic [DEPTH_W-1:0] bus_addr,
    input  logic [DATA_W-1:0]  bus_wdata,
    input  logic               load_we,
    input  logic [DEPTH_W-1:0] load_addr,
    input  logic [DATA_W-1:0]  load_data,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_W];

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end else if (bus_we) begin
            for (int i = 0; i < 2; i++) begin
                if (bus_be[i]) begin
                    mem[bus_addr][i*8 +: 8] <= bus_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sram_responder.sv
// Cycle-accurate SLC-3 SRAM responder: request decode, read-latency FSM,
// byte-lane tristate drive and a side-band program-load port.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH_W  = 10,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned DATA_W   = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    sram_if.slave              bus,
    inout  wire  [DATA_W-1:0]  Data,
    input  logic               load_we,
    input  logic [DEPTH_W-1:0] load_addr,
    input  logic [DATA_W-1:0]  load_data,
    output logic               rd_valid,
    output logic               oob,
    output logic               collision
);

    localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

    state_t      state_q, state_d;
    req_t        req;
    logic [2:0]  cnt_q, cnt_d;
    logic [19:0] cap_q, cap_d;
    logic        oob_d, collision_d;
    logic        restart, enter_drive;
    logic        addr_ok, cap_ok, cap_d_ok, drive;
    logic [1:0]  bus_be;
    logic [DATA_W-1:0] arr_rdata, rword;

    always_comb begin
        req = REQ_NONE;
        if (!bus.CE && !bus.WE) begin
            req = REQ_WR;
        end else if (!bus.CE && !bus.OE) begin
            req = REQ_RD;
        end
    end

    assign addr_ok  = (bus.ADDR[19:DEPTH_W] == '0);
    assign cap_ok   = (cap_q[19:DEPTH_W] == '0);
    assign cap_d_ok = (cap_d[19:DEPTH_W] == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        restart     = 1'b0;
        enter_drive = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req == REQ_RD) restart = 1'b1;
            end
            RD_WAIT: begin
                if (req != REQ_RD) begin
                    state_d = IDLE;
                end else if (bus.ADDR != cap_q) begin
                    restart = 1'b1;
                end else if (cnt_q == 3'd1) begin
                    cnt_d       = 3'd0;
                    state_d     = RD_DRIVE;
                    enter_drive = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RD_DRIVE: begin
                if (req != REQ_RD) begin
                    state_d = IDLE;
                end else if (bus.ADDR != cap_q) begin
                    restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new or changed read address always re-runs the full latency.
        if (restart) begin
            cap_d = bus.ADDR;
            if (READ_LAT == 1) begin
                cnt_d       = 3'd0;
                state_d     = RD_DRIVE;
                enter_drive = 1'b1;
            end else begin
                cnt_d   = LAT_INIT;
                state_d = RD_WAIT;
            end
        end
    end

    assign oob_d       = ((req == REQ_WR) && !addr_ok) || (enter_drive && !cap_d_ok);
    assign collision_d = load_we && (req == REQ_WR);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            cap_q     <= '0;
            oob       <= 1'b0;
            collision <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            oob       <= oob_d;
            collision <= collision_d;
        end
    end

    assign bus_be[HI_LANE] = !bus.UB;
    assign bus_be[LO_LANE] = !bus.LB;

    sram_array #(
        .DEPTH_W (DEPTH_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk       (Clk),
        .bus_we    ((req == REQ_WR) && addr_ok),
        .bus_be    (bus_be),
        .bus_addr  (bus.ADDR[DEPTH_W-1:0]),
        .bus_wdata (Data),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .raddr     (cap_q[DEPTH_W-1:0]),
        .rdata     (arr_rdata)
    );

    assign rword = cap_ok ? arr_rdata : '0;

    // Drive only while the held request still matches the captured read, so a
    // changed address or any control change floats the bus before the next edge.
    assign drive    = (state_q == RD_DRIVE) && !Reset && (req == REQ_RD) && (bus.ADDR == cap_q);
    assign rd_valid = drive;

    assign Data[HI_LANE*8 +: 8] = (drive && !bus.UB) ? rword[HI_LANE*8 +: 8] : Z_WORD[15:8];
    assign Data[LO_LANE*8 +: 8] = (drive && !bus.LB) ? rword[LO_LANE*8 +: 8] : Z_WORD[7:0];

endmodule
